model_arbiter: RTL and testbench

MODEL_ARBITER -- requirements
Module: model_arbiter

---
 rtl/model_pkg.sv | 17 +
 rtl/model_arb_fifo.sv | 48 ++++
 rtl/model_arbiter.sv | 171 +++++++++++++++++
 tb/tb_model_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/model_pkg.sv
// Shared types and default sizing for the MODEL request arbiter slice.
`ifndef BITWIDTH
`define BITWIDTH 16
`endif

package model_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_REQ         = 4;
  localparam int DEF_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/model_arb_fifo.sv
// Synchronous FIFO with wrap-bit pointers; used for the tag and result queues.
module model_arb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head      = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; a push into a full queue is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      wr_ptr_r <= push_ok_s ? wr_ptr_r + (AW+1)'(1) : wr_ptr_r;
      rd_ptr_r <= pop_ok_s  ? rd_ptr_r + (AW+1)'(1) : rd_ptr_r;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/model_arbiter.sv
// Round-robin arbiter sharing one MODEL instance among NUM_REQ requesters,
// with credit-limited issue and in-order response routing.
module model_arbiter
  import model_pkg::*;
#(
  parameter int BITWIDTH        = `BITWIDTH,
  parameter int NUM_REQ         = DEF_NUM_REQ,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                        i_CLK,
  input  logic                        i_nRST,
  input  logic [NUM_REQ-1:0]          i_REQ_VALID,
  input  logic [NUM_REQ*BITWIDTH-1:0] i_REQ_DATA,
  output logic [NUM_REQ-1:0]          o_REQ_READY,
  output logic [NUM_REQ-1:0]          o_RSP_VALID,
  output logic [BITWIDTH-1:0]         o_RSP_DATA,
  input  logic [NUM_REQ-1:0]          i_RSP_READY,
  output logic                        o_M_VALID,
  output logic [BITWIDTH-1:0]         o_M_DATA,
  input  logic                        i_M_VALID,
  input  logic [BITWIDTH-1:0]         i_M_DATA,
  input  logic                        i_HALT,
  output logic                        o_IDLE,
  output logic                        o_ERR
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  arb_state_t          state_r;
  logic [IW-1:0]       ptr_r;
  logic [IW-1:0]       grant_idx_s;
  logic [IW-1:0]       tag_head_s;
  logic [CW-1:0]       count_r;
  logic [CW-1:0]       count_next_s;
  logic [CW-1:0]       unmatched_r;
  logic                found_s;
  logic                can_issue_s;
  logic                accept_s;
  logic                rsp_avail_s;
  logic                rsp_hs_s;
  logic                res_push_s;
  logic                err_hit_s;
  logic                tag_full_s;
  logic                tag_empty_s;
  logic                res_full_s;
  logic                res_empty_s;
  logic [BITWIDTH-1:0] res_head_s;
  logic                m_valid_r;
  logic [BITWIDTH-1:0] m_data_r;
  logic                err_r;

  function automatic logic [IW-1:0] wrap_idx(input int v);
    return IW'(v % NUM_REQ);
  endfunction

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_s && i_REQ_VALID[wrap_idx(int'(ptr_r) + i)]) begin
        found_s     = 1'b1;
        grant_idx_s = wrap_idx(int'(ptr_r) + i);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign can_issue_s = i_nRST && (state_r == ST_RUN) && (count_r < MAX_CNT) && !tag_full_s;
  assign accept_s    = found_s && can_issue_s;
  assign rsp_avail_s = !res_empty_s && !tag_empty_s;
  assign rsp_hs_s    = rsp_avail_s && i_RSP_READY[tag_head_s];
  // A result with no issued tag behind it, or with no room, is flagged and dropped.
  assign err_hit_s   = i_M_VALID && ((unmatched_r == '0) || res_full_s);
  assign res_push_s  = i_M_VALID && !err_hit_s;

  // Grant and response one-hot decode
  always_comb begin
    o_REQ_READY = '0;
    o_RSP_VALID = '0;
    if (accept_s) begin
      o_REQ_READY[grant_idx_s] = 1'b1;
    end else begin
      o_REQ_READY = '0;
    end
    if (rsp_avail_s) begin
      o_RSP_VALID[tag_head_s] = 1'b1;
    end else begin
      o_RSP_VALID = '0;
    end
  end

  // Outstanding count after this cycle's issue/handshake
  always_comb begin
    case ({accept_s, rsp_hs_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Control FSM, pointer, credits, MODEL issue and sticky error
  always_ff @(posedge i_CLK) begin
    if (!i_nRST) begin
      state_r     <= ST_RUN;
      ptr_r       <= '0;
      count_r     <= '0;
      unmatched_r <= '0;
      m_valid_r   <= 1'b0;
      m_data_r    <= '0;
      err_r       <= 1'b0;
    end else begin
      count_r   <= count_next_s;
      m_valid_r <= accept_s;
      m_data_r  <= accept_s ? i_REQ_DATA[grant_idx_s*BITWIDTH +: BITWIDTH] : '0;
      ptr_r     <= accept_s ? wrap_idx(int'(grant_idx_s) + 1) : ptr_r;
      err_r     <= err_r | err_hit_s;
      case ({accept_s, res_push_s})
        2'b10:   unmatched_r <= unmatched_r + CW'(1);
        2'b01:   unmatched_r <= unmatched_r - CW'(1);
        default: unmatched_r <= unmatched_r;
      endcase
      case (state_r)
        ST_RUN:    state_r <= i_HALT ? ST_DRAIN : ST_RUN;
        ST_DRAIN: begin
          if (!i_HALT) begin
            state_r <= ST_RUN;
          end else if (count_next_s == '0) begin
            state_r <= ST_HALTED;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_HALTED: state_r <= i_HALT ? ST_HALTED : ST_RUN;
        default:   state_r <= ST_RUN;
      endcase
    end
  end

  model_arb_fifo #(.WIDTH(IW), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk      (i_CLK),
    .rst_n    (i_nRST),
    .push     (accept_s),
    .push_data(grant_idx_s),
    .pop      (rsp_hs_s),
    .head     (tag_head_s),
    .full     (tag_full_s),
    .empty    (tag_empty_s)
  );

  model_arb_fifo #(.WIDTH(BITWIDTH), .DEPTH(MAX_OUTSTANDING)) u_res_fifo (
    .clk      (i_CLK),
    .rst_n    (i_nRST),
    .push     (res_push_s),
    .push_data(i_M_DATA),
    .pop      (rsp_hs_s),
    .head     (res_head_s),
    .full     (res_full_s),
    .empty    (res_empty_s)
  );

  assign o_RSP_DATA = rsp_avail_s ? res_head_s : '0;
  assign o_M_VALID  = m_valid_r;
  assign o_M_DATA   = m_data_r;
  assign o_IDLE     = (state_r == ST_HALTED);
  assign o_ERR      = err_r;

endmodule

// File: tb/tb_model_arbiter.sv
// Directed bench for model_arbiter with a two-cycle inverting MODEL stand-in.
module tb_model_arbiter;

  localparam int BW = 16;
  localparam int NR = 4;
  localparam int MO = 4;

  logic             clk = 1'b0;
  logic             nrst;
  logic [NR-1:0]    req_valid;
  logic [NR*BW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [BW-1:0]    rsp_data;
  logic [NR-1:0]    rsp_ready;
  logic             m_out_valid;
  logic [BW-1:0]    m_out_data;
  logic             m_in_valid;
  logic [BW-1:0]    m_in_data;
  logic             halt;
  logic             idle;
  logic             err;
  logic             s1v, s2v, inj_v;
  logic [BW-1:0]    s1d, s2d, inj_d;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  model_arbiter #(.BITWIDTH(BW), .NUM_REQ(NR), .MAX_OUTSTANDING(MO)) dut (
    .i_CLK(clk), .i_nRST(nrst),
    .i_REQ_VALID(req_valid), .i_REQ_DATA(req_data), .o_REQ_READY(req_ready),
    .o_RSP_VALID(rsp_valid), .o_RSP_DATA(rsp_data), .i_RSP_READY(rsp_ready),
    .o_M_VALID(m_out_valid), .o_M_DATA(m_out_data),
    .i_M_VALID(m_in_valid), .i_M_DATA(m_in_data),
    .i_HALT(halt), .o_IDLE(idle), .o_ERR(err)
  );

  // MODEL stand-in: result = ~operand, two cycles after o_M_VALID
  always @(posedge clk) begin
    if (!nrst) begin
      s1v <= 1'b0; s2v <= 1'b0; s1d <= '0; s2d <= '0;
    end else begin
      s1v <= m_out_valid; s1d <= ~m_out_data;
      s2v <= s1v;         s2d <= s1d;
    end
  end
  assign m_in_valid = s2v | inj_v;
  assign m_in_data  = inj_v ? inj_d : s2d;

  task automatic pulse_reset();
    @(negedge clk); nrst = 1'b0;
    @(negedge clk); nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; req_valid = 4'b1111;
    @(negedge clk); @(negedge clk); #1;
    vec++; if (req_ready !== 4'b0000) begin miss++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    vec++; if (rsp_valid !== 4'b0000) begin miss++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    vec++; if (m_out_valid !== 1'b0 || m_out_data !== 16'h0000) begin miss++; $display("FAIL reset_m_out: got %b/%h want 0/0000", m_out_valid, m_out_data); end
    vec++; if (rsp_data !== 16'h0000) begin miss++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); end
    vec++; if (idle !== 1'b0 || err !== 1'b0) begin miss++; $display("FAIL reset_idle_err: got %b/%b want 0/0", idle, err); end
    req_valid = 4'b0000; nrst = 1'b1;
  endtask

  task automatic test_single();
    int n;
    @(negedge clk); req_data[1*BW +: BW] = 16'h00A5; req_valid = 4'b0010; #1;
    vec++; if (req_ready !== 4'b0010) begin miss++; $display("FAIL single_grant: got %b want 0010", req_ready); end
    @(negedge clk); req_valid = 4'b0000; #1;
    vec++; if (m_out_valid !== 1'b1 || m_out_data !== 16'h00A5) begin miss++; $display("FAIL single_issue: got %b/%h want 1/00a5", m_out_valid, m_out_data); end
    @(negedge clk); #1;
    vec++; if (m_out_valid !== 1'b0) begin miss++; $display("FAIL single_issue_pulse: got %b want 0", m_out_valid); end
    n = 1;
    while (rsp_valid == 4'b0000 && n < 20) begin @(negedge clk); #1; n++; end
    vec++; if (n !== 3) begin miss++; $display("FAIL single_latency: got %0d want 3", n); end
    vec++; if (rsp_valid !== 4'b0010 || rsp_data !== 16'hFF5A) begin miss++; $display("FAIL single_rsp: got %b/%h want 0010/ff5a", rsp_valid, rsp_data); end
    @(negedge clk); #1;
    vec++; if (rsp_valid !== 4'b0000) begin miss++; $display("FAIL single_pop: got %b want 0000", rsp_valid); end
  endtask

  task automatic test_round_robin();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    int ngr = 0;
    int nrs = 0;
    logic [3:0] oh;
    pulse_reset();
    for (int k = 0; k < NR; k++) req_data[k*BW +: BW] = 16'hA000 + 16'(k);
    @(negedge clk); req_valid = 4'b1111;
    for (int c = 0; c < 60 && nrs < 5; c++) begin
      #1;
      vec++; if ($countones(req_ready) > 1) begin miss++; $display("FAIL rr_onehot: got %b want <=1 bit", req_ready); end
      if (req_ready != 4'b0000 && ngr < 5) begin
        oh = 4'b0001 << exp_seq[ngr];
        vec++; if (req_ready !== oh) begin miss++; $display("FAIL rr_grant%0d: got %b want %b", ngr, req_ready, oh); end
        ngr++;
      end
      if (rsp_valid != 4'b0000 && nrs < 5) begin
        oh = 4'b0001 << exp_seq[nrs];
        vec++;
        if (rsp_valid !== oh || rsp_data !== ~(16'hA000 + 16'(exp_seq[nrs]))) begin
          miss++; $display("FAIL rr_rsp%0d: got %b/%h want %b/%h", nrs, rsp_valid, rsp_data, oh, ~(16'hA000 + 16'(exp_seq[nrs])));
        end
        nrs++;
      end
      @(negedge clk);
      if (ngr == 5) req_valid = 4'b0000;
    end
    req_valid = 4'b0000;
    vec++; if (ngr !== 5 || nrs !== 5) begin miss++; $display("FAIL rr_timeout: got %0d grants %0d rsps want 5/5", ngr, nrs); end
  endtask

  task automatic test_backpressure();
    int ngr = 0;
    int nrs;
    @(negedge clk); rsp_ready = 4'b1011; req_data[2*BW +: BW] = 16'h0C02; req_valid = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      #1; if (req_ready != 4'b0000) ngr++;
      @(negedge clk);
    end
    #1;
    vec++; if (ngr !== 4) begin miss++; $display("FAIL bp_credit: got %0d grants want 4", ngr); end
    vec++; if (req_ready !== 4'b0000) begin miss++; $display("FAIL bp_blocked: got %b want 0000", req_ready); end
    vec++; if (rsp_valid !== 4'b0100 || rsp_data !== 16'hF3FD) begin miss++; $display("FAIL bp_head: got %b/%h want 0100/f3fd", rsp_valid, rsp_data); end
    rsp_ready = 4'b1111;
    @(negedge clk); #1;
    vec++; if (req_ready !== 4'b0100) begin miss++; $display("FAIL bp_resume: got %b want 0100", req_ready); end
    nrs = (rsp_valid != 4'b0000) ? 1 : 0;
    @(negedge clk); req_valid = 4'b0000;
    for (int c = 0; c < 30; c++) begin
      #1; if (rsp_valid != 4'b0000) nrs++;
      @(negedge clk);
    end
    vec++; if (nrs !== 4) begin miss++; $display("FAIL bp_drain: got %0d rsps want 4", nrs); end
    vec++; if (err !== 1'b0) begin miss++; $display("FAIL bp_err: got %b want 0", err); end
  endtask

  task automatic test_halt();
    int ngr = 0;
    int nrs = 0;
    bit seen = 1'b0;
    @(negedge clk); rsp_ready = 4'b0000; req_data[0 +: BW] = 16'h0D00; req_valid = 4'b0001;
    for (int c = 0; c < 20 && ngr < 3; c++) begin
      #1; if (req_ready != 4'b0000) ngr++;
      @(negedge clk);
      if (ngr == 3) req_valid = 4'b0000;
    end
    repeat (8) @(negedge clk);
    halt = 1'b1;
    @(negedge clk); req_valid = 4'b1111; #1;
    vec++; if (req_ready !== 4'b0000 || idle !== 1'b0) begin miss++; $display("FAIL halt_nogrant: got %b/%b want 0000/0", req_ready, idle); end
    rsp_ready = 4'b1111;
    for (int c = 0; c < 20 && nrs < 3; c++) begin
      if (rsp_valid != 4'b0000) nrs++;
      vec++; if (idle !== 1'b0 || req_ready !== 4'b0000) begin miss++; $display("FAIL halt_drain: got idle %b ready %b want 0/0000", idle, req_ready); end
      @(negedge clk); #1;
    end
    vec++; if (nrs !== 3 || idle !== 1'b1) begin miss++; $display("FAIL halt_idle: got %0d rsps idle %b want 3/1", nrs, idle); end
    halt = 1'b0;
    @(negedge clk); #1;
    vec++; if (req_ready !== 4'b0010 || idle !== 1'b0) begin miss++; $display("FAIL halt_resume: got %b/%b want 0010/0", req_ready, idle); end
    @(negedge clk); req_valid = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      #1; if (rsp_valid == 4'b0010) seen = 1'b1;
      @(negedge clk);
    end
    vec++; if (seen !== 1'b1) begin miss++; $display("FAIL halt_resume_rsp: got %b want 1", seen); end
  endtask

  task automatic test_err();
    @(negedge clk); #1;
    vec++; if (err !== 1'b0) begin miss++; $display("FAIL err_pre: got %b want 0", err); end
    inj_d = 16'hBEEF; inj_v = 1'b1;
    @(negedge clk); inj_v = 1'b0; #1;
    vec++; if (err !== 1'b1) begin miss++; $display("FAIL err_set: got %b want 1", err); end
    repeat (5) @(negedge clk);
    #1;
    vec++; if (err !== 1'b1 || rsp_valid !== 4'b0000) begin miss++; $display("FAIL err_sticky: got %b/%b want 1/0000", err, rsp_valid); end
  endtask

  task automatic test_reset_mid();
    int ngr = 0;
    bit stale = 1'b0;
    pulse_reset();
    #1;
    vec++; if (err !== 1'b0) begin miss++; $display("FAIL rmid_err_clear: got %b want 0", err); end
    @(negedge clk); req_data[3*BW +: BW] = 16'h3333; req_valid = 4'b1000;
    for (int c = 0; c < 20 && ngr < 2; c++) begin
      #1; if (req_ready != 4'b0000) ngr++;
      @(negedge clk);
    end
    nrst = 1'b0; req_valid = 4'b1111; #1;
    vec++; if (req_ready !== 4'b0000) begin miss++; $display("FAIL rmid_ready: got %b want 0000", req_ready); end
    @(negedge clk); #1;
    vec++;
    if (m_out_valid !== 1'b0 || m_out_data !== 16'h0000 || rsp_valid !== 4'b0000 || rsp_data !== 16'h0000 || idle !== 1'b0 || err !== 1'b0) begin
      miss++; $display("FAIL rmid_outputs: got mv %b md %h rv %b rd %h idle %b err %b want all 0", m_out_valid, m_out_data, rsp_valid, rsp_data, idle, err);
    end
    nrst = 1'b1; req_valid = 4'b0000;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (rsp_valid != 4'b0000 || err != 1'b0) stale = 1'b1;
    end
    vec++; if (stale !== 1'b0) begin miss++; $display("FAIL rmid_stale: got %b want 0", stale); end
  endtask

  initial begin
    nrst = 1'b0; req_valid = '0; req_data = '0; rsp_ready = '1;
    halt = 1'b0; inj_v = 1'b0; inj_d = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_halt();
    test_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
